snax_gemmx_csr_manager: RTL and testbench

CSR manager that sits between the Snitch core's CSR request port and the GEMMX accelerator shell's CSR manager ports. It is the driving end of the csr_reg_set handshake. It holds staged RW configuration registers and commits them as a stable snapshot on a launch write. It presents the snapshot with a valid/ready handshake and serves core reads of staged RW, launch-status and RO registers.

---
 rtl/snax_gemmx_csr_manager.sv | 137 +++++++++++++
 tb/tb_snax_gemmx_csr_manager.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_gemmx_csr_manager.sv
// CSR manager between the Snitch CSR request port and the GEMMX shell: stages RW
// registers, commits them as a snapshot on launch, and answers core reads.
module snax_gemmx_csr_manager #(
  parameter int unsigned RegRWCount   = 19,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [RegAddrWidth-1:0]                   csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                   csr_req_data_i,
  input  logic                                      csr_req_write_i,
  input  logic                                      csr_req_valid_i,
  output logic                                      csr_req_ready_o,
  output logic [RegDataWidth-1:0]                   csr_rsp_data_o,
  output logic                                      csr_rsp_valid_o,
  input  logic                                      csr_rsp_ready_i,
  output logic [RegRWCount-1:0][RegDataWidth-1:0]   csr_reg_set_o,
  output logic                                      csr_reg_set_valid_o,
  input  logic                                      csr_reg_set_ready_i,
  input  logic [RegROCount-1:0][RegDataWidth-1:0]   csr_reg_ro_set_i
);

  localparam int unsigned RwIdxW = (RegRWCount > 1) ? $clog2(RegRWCount) : 1;
  localparam int unsigned RoIdxW = (RegROCount > 1) ? $clog2(RegROCount) : 1;
  localparam logic [RegAddrWidth-1:0] LaunchIdx = RegAddrWidth'(RegRWCount);
  localparam logic [RegAddrWidth-1:0] RoLastIdx = RegAddrWidth'(RegRWCount + RegROCount);

  typedef enum logic {IDLE, LAUNCH} state_e;

  state_e                                  state_q, state_d;
  logic [RegRWCount-1:0][RegDataWidth-1:0] staging_q, staging_d;
  logic [RegRWCount-1:0][RegDataWidth-1:0] snapshot_q, snapshot_d;
  logic                                    rsp_valid_q, rsp_valid_d;
  logic [RegDataWidth-1:0]                 rsp_data_q, rsp_data_d;

  logic                    is_rw, is_launch, is_ro;
  logic                    launch_req, rsp_slot_free, req_accept;
  logic [RwIdxW-1:0]       rw_idx;
  logic [RoIdxW-1:0]       ro_idx;
  logic [RegDataWidth-1:0] rd_data;

  // Address decode: the address is a register index, not a byte address.
  always_comb begin
    is_rw      = (csr_req_addr_i < LaunchIdx);
    is_launch  = (csr_req_addr_i == LaunchIdx);
    is_ro      = (csr_req_addr_i > LaunchIdx) && (csr_req_addr_i <= RoLastIdx);
    rw_idx     = RwIdxW'(csr_req_addr_i);
    ro_idx     = RoIdxW'(csr_req_addr_i - LaunchIdx - RegAddrWidth'(1));
    launch_req = csr_req_write_i && is_launch && csr_req_data_i[0];
  end

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and a raised valid holds its payload stable
  // until that transfer. Reads need a free response slot (empty or draining this
  // cycle); a launch write needs IDLE; every other write is always taken.
  always_comb begin
    rsp_slot_free = !rsp_valid_q || csr_rsp_ready_i;
    if (!csr_req_write_i) begin
      csr_req_ready_o = rsp_slot_free;
    end else if (launch_req) begin
      csr_req_ready_o = (state_q == IDLE);
    end else begin
      csr_req_ready_o = 1'b1;
    end
    req_accept = csr_req_valid_i && csr_req_ready_o;
  end

  always_comb begin
    rd_data = '0;
    if (is_rw) begin
      rd_data = staging_q[rw_idx];
    end else if (is_launch) begin
      rd_data = RegDataWidth'(state_q == LAUNCH);
    end else if (is_ro) begin
      rd_data = csr_reg_ro_set_i[ro_idx];
    end
  end

  always_comb begin
    staging_d   = staging_q;
    snapshot_d  = snapshot_q;
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (req_accept && csr_req_write_i && is_rw) begin
      staging_d[rw_idx] = csr_req_data_i;
    end

    // The snapshot takes staging as it stood before this edge.
    case (state_q)
      IDLE: begin
        if (req_accept && launch_req) begin
          snapshot_d = staging_q;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (csr_reg_set_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (req_accept && !csr_req_write_i) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_data;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      staging_q   <= '0;
      snapshot_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      staging_q   <= staging_d;
      snapshot_q  <= snapshot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign csr_rsp_valid_o     = rsp_valid_q;
  assign csr_rsp_data_o      = rsp_data_q;
  assign csr_reg_set_o       = snapshot_q;
  assign csr_reg_set_valid_o = (state_q == LAUNCH);

endmodule

// File: tb/tb_snax_gemmx_csr_manager.sv
// Bench for snax_gemmx_csr_manager: table of register accesses, then hand-written
// launch, backpressure and async-reset sequences; read data checked via a queue.
module tb_snax_gemmx_csr_manager;

  localparam int RW = 19;
  localparam int RO = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]          req_addr = '0;
  logic [DW-1:0]          req_data = '0;
  logic                   req_write = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [RW-1:0][DW-1:0]  reg_set;
  logic                   set_valid;
  logic                   set_ready = 1'b0;
  logic [RO-1:0][DW-1:0]  ro_set;

  snax_gemmx_csr_manager #(
    .RegRWCount(RW), .RegROCount(RO), .RegDataWidth(DW), .RegAddrWidth(AW)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .csr_req_addr_i      (req_addr),
    .csr_req_data_i      (req_data),
    .csr_req_write_i     (req_write),
    .csr_req_valid_i     (req_valid),
    .csr_req_ready_o     (req_ready),
    .csr_rsp_data_o      (rsp_data),
    .csr_rsp_valid_o     (rsp_valid),
    .csr_rsp_ready_i     (rsp_ready),
    .csr_reg_set_o       (reg_set),
    .csr_reg_set_valid_o (set_valid),
    .csr_reg_set_ready_i (set_ready),
    .csr_reg_ro_set_i    (ro_set)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stage_m[RW];
  logic [DW-1:0] snap_m[RW];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_snap(input string name);
    for (int i = 0; i < RW; i++) check($sformatf("%s_word%0d", name, i), reg_set[i], snap_m[i]);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_rsp: got response data %0d, expected no response", rsp_data);
      end else begin
        check("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e, output int waits);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    waits     = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL req_timeout: addr %0d not accepted in 50 cycles, expected acceptance", a);
      @(posedge clk);
    end else begin
      @(posedge clk);
      if (!wr) exp_q.push_back(e);
      else if (a < RW) stage_m[a] = d;
      else if (a == RW && d[0] && !set_valid) snap_m = stage_m;
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 20);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    ro_set[0] = 32'd1;
    ro_set[1] = 32'd1234;
    for (int i = 0; i < RW; i++) begin
      stage_m[i] = '0;
      snap_m[i]  = '0;
    end

    for (int i = 0; i < RW; i++) add(1'b0, i, 0, 0);
    add(1'b0, 19, 0, 0);
    add(1'b0, 24, 0, 0);
    add(1'b1, 0, 64, 0);
    add(1'b1, 1, 32, 0);
    add(1'b1, 2, 16, 0);
    add(1'b1, 17, 1, 0);
    add(1'b0, 0, 0, 64);
    add(1'b0, 1, 0, 32);
    add(1'b0, 2, 0, 16);
    add(1'b0, 17, 0, 1);
    add(1'b0, 3, 0, 0);
    add(1'b0, 20, 0, 1);
    add(1'b0, 21, 0, 1234);
    add(1'b1, 20, 99, 0);
    add(1'b0, 20, 0, 1);
    add(1'b1, 24, 5, 0);
    add(1'b0, 24, 0, 0);
    add(1'b0, 22, 0, 0);
    add(1'b1, 19, 0, 0);
    add(1'b0, 19, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_set_valid", set_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check_snap("rst_snap");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: reset reads, staging writes, RO passthrough, unmapped, launch bit0=0.
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, w);
      check("tbl_no_launch", set_valid, 0);
    end
    wait_drain();
    check_snap("pre_launch_snap");

    // Basic launch with the accelerator stalling 5 cycles.
    set_ready = 1'b0;
    do_req(1'b1, 19, 1, 0, w);
    check("launch_valid_rise", set_valid, 1);
    check_snap("launch_snap");
    repeat (5) begin
      @(negedge clk);
      check("launch_hold_valid", set_valid, 1);
      check_snap("launch_hold_snap");
    end
    @(posedge clk);
    #1;

    // Staging during LAUNCH.
    do_req(1'b1, 0, 7, 0, w);
    check("stage_in_launch_waits", w, 0);
    do_req(1'b0, 0, 0, 7, w);
    do_req(1'b0, 19, 0, 1, w);
    wait_drain();
    check("snap_word0_kept", reg_set[0], 64);

    // Second launch stalls until the first handshake completes.
    fork
      do_req(1'b1, 19, 1, 0, w);
      begin
        repeat (3) begin
          @(negedge clk);
          check("relaunch_stall_ready", req_ready, 0);
          check("relaunch_stall_valid", set_valid, 1);
        end
        @(posedge clk);
        #1;
        set_ready = 1'b1;
        @(negedge clk);
        check("complete_cycle_valid", set_valid, 1);
        check("complete_cycle_ready", req_ready, 0);
        @(posedge clk);
        #1;
        set_ready = 1'b0;
        @(negedge clk);
        check("after_complete_valid", set_valid, 0);
        check("after_complete_ready", req_ready, 1);
      end
    join
    check("relaunch_valid", set_valid, 1);
    check("relaunch_word0", reg_set[0], 7);
    check_snap("relaunch_snap");
    set_ready = 1'b1;
    @(negedge clk);
    check("relaunch_hs_valid", set_valid, 1);
    @(posedge clk);
    #1;
    set_ready = 1'b0;
    check("relaunch_drop", set_valid, 0);
    check_snap("idle_snap_persist");

    // Response backpressure: three reads with the core stalled for 4 cycles.
    rsp_ready = 1'b0;
    do_req(1'b0, 0, 0, 7, w);
    fork
      begin
        do_req(1'b0, 1, 0, 32, w);
        do_req(1'b0, 2, 0, 16, w);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_rsp_valid", rsp_valid, 1);
          check("bp_rsp_data", rsp_data, 7);
          check("bp_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_stream_valid", rsp_valid, 1);
        end
      end
    join
    wait_drain();

    // Async reset mid-launch.
    do_req(1'b1, 3, 5, 0, w);
    do_req(1'b1, 19, 1, 0, w);
    check("pre_reset_valid", set_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", set_valid, 0);
    exp_q.delete();
    for (int i = 0; i < RW; i++) begin
      stage_m[i] = '0;
      snap_m[i]  = '0;
    end
    check_snap("async_reset_snap");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_req(1'b0, 0, 0, 0, w);
    do_req(1'b0, 3, 0, 0, w);
    do_req(1'b0, 19, 0, 0, w);
    wait_drain();
    check("post_reset_valid", set_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
